// File: rtl/nrisc_int_controller_if.sv
// Core-facing bus of the NRISC interrupt controller: configuration access plus
// the interrupt vector / command channel.
interface nrisc_int_controller_if #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned CHA_W   = 8
);
    logic               cfg_we;
    logic               cfg_addr;
    logic [NUM_IRQ-1:0] cfg_wdata;
    logic [NUM_IRQ-1:0] cfg_rdata;
    logic [1:0]         int_ctrl;
    logic               int_req;
    logic [CHA_W-1:0]   int_cha;
    logic               int_busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, int_ctrl,
        input  cfg_rdata, int_req, int_cha, int_busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, int_ctrl,
        output cfg_rdata, int_req, int_cha, int_busy
    );
endinterface

// File: rtl/nrisc_int_controller.sv
// Fixed-priority, non-nesting interrupt controller: latches lines into pending
// bits, masks them, and hands the lowest eligible line to the core.
module nrisc_int_controller #(
    parameter int unsigned NUM_IRQ  = 8,
    parameter int unsigned CHA_W    = 8,
    parameter int unsigned VEC_BASE = 'h10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IRQ-1:0]     irq_in,
    output logic [NUM_IRQ-1:0]     pending,
    nrisc_int_controller_if.slave  bus
);
    localparam int unsigned SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_ACK,
        CMD_EOI,
        CMD_CLEAR_ALL
    } cmd_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] prev_q;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CHA_W-1:0]   cha_q, cha_d;

    cmd_e               cmd;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] set_v;
    logic [NUM_IRQ-1:0] clr_v;
    logic [SEL_W-1:0]   arb_sel;
    logic               arb_found;
    logic               mask_drop;

    assign cmd = cmd_e'(bus.int_ctrl);

    always_comb begin
        eligible  = pend_q & mask_q;
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !arb_found) begin
                arb_found = 1'b1;
                arb_sel   = SEL_W'(i);
            end
        end
    end

    // Set terms are OR-ed in after the clear so a simultaneous set always wins.
    always_comb begin
        set_v = irq_in & ~(edge_q & prev_q);
        clr_v = '0;
        if (cmd == CMD_CLEAR_ALL) begin
            clr_v = '1;
        end else if (cmd == CMD_ACK && state_q == S_REQ) begin
            clr_v = NUM_IRQ'(1) << sel_q;
        end
        pend_d = (pend_q & ~clr_v) | set_v;

        mask_d = mask_q;
        edge_d = edge_q;
        if (bus.cfg_we) begin
            if (bus.cfg_addr) begin
                edge_d = bus.cfg_wdata;
            end else begin
                mask_d = bus.cfg_wdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cha_d     = cha_q;
        mask_drop = bus.cfg_we && !bus.cfg_addr && !bus.cfg_wdata[sel_q];
        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    sel_d   = arb_sel;
                    cha_d   = CHA_W'(VEC_BASE + 32'(arb_sel));
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (cmd == CMD_ACK) begin
                    state_d = S_SERVICE;
                end else if (cmd == CMD_CLEAR_ALL || mask_drop) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (cmd == CMD_EOI) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            edge_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            sel_q   <= '0;
            cha_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
            prev_q  <= irq_in;
            sel_q   <= sel_d;
            cha_q   <= cha_d;
        end
    end

    assign pending       = pend_q;
    assign bus.cfg_rdata = bus.cfg_addr ? edge_q : mask_q;
    assign bus.int_req   = (state_q == S_REQ);
    assign bus.int_busy  = (state_q == S_SERVICE);
    assign bus.int_cha   = cha_q;
endmodule
